// File: rtl/hlr_div_pkg.sv
// Shared types and default widths for the sequential 16/8 signed divider.
package hlr_div_pkg;
  localparam int DW_A_DEF = 16;
  localparam int DW_B_DEF = 8;
  localparam int QMAX     = 127;
  localparam int QMIN     = -128;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
endpackage

// File: rtl/hlr_div_sign_fix.sv
// Combinational sign restore, overflow detect and divide-by-zero result for the divider.
// HLR_DIV_SAT_EN: clamp the quotient on ovf/dz instead of wrapping to the low DW_B bits.
module hlr_div_sign_fix #(
  parameter int DW_A = 16,
  parameter int DW_B = 8
) (
  input  logic [DW_A-1:0] qmag_i,
  input  logic [DW_B-1:0] rmag_i,
  input  logic            a_neg_i,
  input  logic            b_neg_i,
  input  logic            dz_i,
  input  logic [DW_B-1:0] dz_rem_i,
  output logic [DW_B-1:0] quo_o,
  output logic [DW_B-1:0] rem_o,
  output logic            ovf_o
);
  localparam logic [DW_A-1:0] LIM   = DW_A'(1) << (DW_B - 1);
  localparam logic [DW_B-1:0] Q_POS = {1'b0, {(DW_B-1){1'b1}}};
  localparam logic [DW_B-1:0] Q_NEG = {1'b1, {(DW_B-1){1'b0}}};

  logic q_neg;

  always_comb begin
    q_neg = a_neg_i ^ b_neg_i;
    // A negative quotient may reach magnitude 2^(DW_B-1); a positive one may not.
    ovf_o = dz_i ? 1'b0 : (q_neg ? (qmag_i > LIM) : (qmag_i >= LIM));
    quo_o = dz_i ? '1 : (q_neg ? -qmag_i[DW_B-1:0] : qmag_i[DW_B-1:0]);
    rem_o = dz_i ? dz_rem_i : (a_neg_i ? -rmag_i : rmag_i);
`ifdef HLR_DIV_SAT_EN
    if (dz_i) begin
      quo_o = a_neg_i ? Q_NEG : Q_POS;
    end else if (ovf_o) begin
      quo_o = q_neg ? Q_NEG : Q_POS;
    end
`endif
  end
endmodule

// File: rtl/hlr_seq_div16by8.sv
// Signed restoring divider, one quotient bit per cycle; result DW_A+2 cycles after accept (1 on divide-by-zero).
// Result held until out_ready; no new operands accepted while busy. HLR_DIV_SAT_EN selects a saturating quotient.
module hlr_seq_div16by8
  import hlr_div_pkg::*;
#(
  parameter int DW_A = DW_A_DEF,
  parameter int DW_B = DW_B_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW_A-1:0] dividend,
  input  logic [DW_B-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW_B-1:0] quotient,
  output logic [DW_B-1:0] remainder,
  output logic            ovf,
  output logic            dz
);
  localparam int CW = $clog2(DW_A);

  div_state_t      state_q;
  logic [DW_A-1:0] a_q;  // dividend bits leave at the top, quotient bits enter at the bottom
  logic [DW_B-1:0] r_q;
  logic [DW_B-1:0] b_q;
  logic            a_neg_q;
  logic            b_neg_q;
  logic [CW-1:0]   cnt_q;
  logic            out_valid_q;
  logic            ovf_q;
  logic            dz_q;
  logic [DW_B-1:0] quo_q;
  logic [DW_B-1:0] rem_q;

  logic [DW_B:0]   sh_d;
  logic            qbit_d;
  logic [DW_B-1:0] r_d;
  logic [DW_A-1:0] a_mag_d;
  logic [DW_B-1:0] b_mag_d;

  logic            fix_dz;
  logic            fix_a_neg;
  logic            fix_ovf;
  logic [DW_B-1:0] fix_quo;
  logic [DW_B-1:0] fix_rem;

  // Partial remainder stays below |divisor| <= 2^(DW_B-1), so DW_B bits hold it between steps.
  always_comb begin
    sh_d    = {r_q, a_q[DW_A-1]};
    qbit_d  = (sh_d >= {1'b0, b_q});
    r_d     = qbit_d ? (sh_d[DW_B-1:0] - b_q) : sh_d[DW_B-1:0];
    a_mag_d = dividend[DW_A-1] ? -dividend : dividend;
    b_mag_d = divisor[DW_B-1] ? -divisor : divisor;
  end

  assign fix_dz    = (state_q == IDLE);
  assign fix_a_neg = fix_dz ? dividend[DW_A-1] : a_neg_q;

  hlr_div_sign_fix #(
    .DW_A(DW_A),
    .DW_B(DW_B)
  ) u_sign_fix (
    .qmag_i  (a_q),
    .rmag_i  (r_q),
    .a_neg_i (fix_a_neg),
    .b_neg_i (b_neg_q),
    .dz_i    (fix_dz),
    .dz_rem_i(dividend[DW_B-1:0]),
    .quo_o   (fix_quo),
    .rem_o   (fix_rem),
    .ovf_o   (fix_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      r_q         <= '0;
      b_q         <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quo_q       <= fix_quo;
              rem_q       <= fix_rem;
              ovf_q       <= fix_ovf;
              dz_q        <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              a_q     <= a_mag_d;
              b_q     <= b_mag_d;
              r_q     <= '0;
              a_neg_q <= dividend[DW_A-1];
              b_neg_q <= divisor[DW_B-1];
              cnt_q   <= CW'(DW_A - 1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          a_q   <= {a_q[DW_A-2:0], qbit_d};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quo_q       <= fix_quo;
          rem_q       <= fix_rem;
          ovf_q       <= fix_ovf;
          dz_q        <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;
endmodule

// File: tb/tb_hlr_seq_div16by8.sv
// Directed table-driven bench for hlr_seq_div16by8 plus hold and mid-operation reset sequences.
module tb_hlr_seq_div16by8;
  import hlr_div_pkg::*;

`ifdef HLR_DIV_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ovf;
  logic        dz;

  always #5 clk = ~clk;

  hlr_seq_div16by8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .ovf      (ovf),
    .dz       (dz)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  qw;   // wrapped quotient
    logic [7:0]  qs;   // saturated quotient
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
  } vec_t;

  vec_t tv [17];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Handshake one operation and return the cycle index at which out_valid is first seen.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b, output int lat);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_accept", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int  lat;
    bit  seen;

    tv[0]  = '{16'h0064, 8'h07, 8'h0E, 8'h0E, 8'h02, 1'b0, 1'b0};  //  100 /  7
    tv[1]  = '{16'hFF9C, 8'h07, 8'hF2, 8'hF2, 8'hFE, 1'b0, 1'b0};  // -100 /  7
    tv[2]  = '{16'h0064, 8'hF9, 8'hF2, 8'hF2, 8'h02, 1'b0, 1'b0};  //  100 / -7
    tv[3]  = '{16'hFF9C, 8'hF9, 8'h0E, 8'h0E, 8'hFE, 1'b0, 1'b0};  // -100 / -7
    tv[4]  = '{16'h03E8, 8'h03, 8'h4D, 8'h7F, 8'h01, 1'b1, 1'b0};  // 1000 / 3 = 333
    tv[5]  = '{16'h0032, 8'h00, 8'hFF, 8'h7F, 8'h32, 1'b0, 1'b1};  //   50 / 0
    tv[6]  = '{16'hFFCE, 8'h00, 8'hFF, 8'h80, 8'hCE, 1'b0, 1'b1};  //  -50 / 0
    tv[7]  = '{16'h7FFF, 8'h7F, 8'h02, 8'h7F, 8'h01, 1'b1, 1'b0};  // 32767 / 127 = 258 r 1
    tv[8]  = '{16'hC000, 8'h80, 8'h80, 8'h7F, 8'h00, 1'b1, 1'b0};  // -16384 / -128 = 128
    tv[9]  = '{16'h4000, 8'h80, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0};  // 16384 / -128 = -128
    tv[10] = '{16'h0000, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};  //    0 / 5
    tv[11] = '{16'hFFFF, 8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};  //   -1 / 1
    tv[12] = '{16'hFFF9, 8'h64, 8'h00, 8'h00, 8'hF9, 1'b0, 1'b0};  //   -7 / 100
    tv[13] = '{16'h8000, 8'h01, 8'h00, 8'h80, 8'h00, 1'b1, 1'b0};  // -32768 / 1
    tv[14] = '{16'h00FF, 8'hFE, 8'h81, 8'h81, 8'h01, 1'b0, 1'b0};  //  255 / -2 = -127 r 1
    tv[15] = '{16'hFAF6, 8'h0A, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b0};  // -1290 / 10 = -129
    tv[16] = '{16'h04F6, 8'h0A, 8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0};  // 1270 / 10 = 127

    // Reset state
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      start_op(tv[i].a, tv[i].b, lat);
      chk($sformatf("latency[%0d]", i), lat, tv[i].dz ? 32'd1 : 32'd18);
      chk($sformatf("quotient[%0d]", i), {24'd0, quotient}, {24'd0, SAT ? tv[i].qs : tv[i].qw});
      chk($sformatf("remainder[%0d]", i), {24'd0, remainder}, {24'd0, tv[i].r});
      chk($sformatf("ovf[%0d]", i), {31'd0, ovf}, {31'd0, tv[i].ovf});
      chk($sformatf("dz[%0d]", i), {31'd0, dz}, {31'd0, tv[i].dz});
      chk($sformatf("in_ready_busy[%0d]", i), {31'd0, in_ready}, 32'd0);
      accept();
    end

    // Result held under backpressure while new operands are offered
    start_op(16'd100, 8'd7, lat);
    chk("hold_latency", lat, 32'd18);
    for (int k = 0; k < 5; k++) begin
      dividend = 16'd1000;
      divisor  = 8'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("hold_valid[%0d]", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold_in_ready[%0d]", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("hold_quotient[%0d]", k), {24'd0, quotient}, 32'h0E);
      chk($sformatf("hold_remainder[%0d]", k), {24'd0, remainder}, 32'h02);
      chk($sformatf("hold_ovf[%0d]", k), {31'd0, ovf}, 32'd0);
    end
    in_valid = 1'b0;
    accept();
    repeat (3) @(posedge clk);
    #1;
    chk("post_hold_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hold_quotient", {24'd0, quotient}, 32'h0E);

    // Reset pulsed in the middle of 20 / 4
    dividend = 16'd20;
    divisor  = 8'd4;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_quotient", {24'd0, quotient}, 32'd0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", {31'd0, seen}, 32'd0);

    // Largest magnitudes on both operands
    start_op(16'h8000, 8'h80, lat);
    chk("minmin_latency", lat, 32'd18);
    chk("minmin_quotient", {24'd0, quotient}, SAT ? {24'd0, 8'(QMAX)} : 32'h00);
    chk("minmin_remainder", {24'd0, remainder}, 32'h00);
    chk("minmin_ovf", {31'd0, ovf}, 32'd1);
    chk("minmin_dz", {31'd0, dz}, 32'd0);
    accept();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
